// File: rtl/pipelined_adder_tree_if.sv
// Streaming valid/ready bundle for pipelined_adder_tree.
//   master : operand producer / result consumer side
//   slave  : adder tree side
// Signals:
//   in_valid, in_ready, in_signed, in_data[NUM_IN*WIDTH] : operand set channel
//   out_valid, out_ready, out_data[OW], out_signed       : result channel
interface pipelined_adder_tree_if #(
    parameter int NUM_IN = 10,
    parameter int WIDTH  = 21
);
    localparam int OW = WIDTH + $clog2(NUM_IN);

    logic                    in_valid;
    logic                    in_ready;
    logic                    in_signed;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [OW-1:0]           out_data;
    logic                    out_signed;

    modport master (
        output in_valid, in_signed, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_signed
    );

    modport slave (
        input  in_valid, in_signed, in_data, out_ready,
        output in_ready, out_valid, out_data, out_signed
    );
endinterface

// File: rtl/pipelined_adder_tree.sv
// Pipelined multi-operand adder: sums NUM_IN lanes of WIDTH bits through a
// binary tree with one register stage per level ($clog2(NUM_IN) stages).
// Each lane is sign- or zero-extended to OW bits at entry according to the
// per-transaction mode bit, which travels alongside the partial sums.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pipelined_adder_tree_if (operand set in, sum out)
module pipelined_adder_tree #(
    parameter int NUM_IN = 10,
    parameter int WIDTH  = 21
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipelined_adder_tree_if.slave  bus
);
    localparam int LVL = $clog2(NUM_IN);
    localparam int OW  = WIDTH + LVL;

    // Number of operands present at tree level k (level 0 = extended lanes).
    function automatic int lvl_cnt(input int k);
        int n;
        n = NUM_IN;
        for (int unsigned i = 0; i < k; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    logic stall;

    // A held result freezes the whole pipe, bubbles included.
    always_comb begin
        stall        = bus.out_valid & ~bus.out_ready;
        bus.in_ready = ~stall & rst_n;
    end

    for (genvar k = 0; k <= LVL; k++) begin : g_lvl
        localparam int CNT = lvl_cnt(k);

        logic [OW-1:0] sum [CNT];
        logic          vld;
        logic          sgn;

        if (k == 0) begin : g_ext
            always_comb begin
                vld = bus.in_valid & bus.in_ready;
                sgn = bus.in_signed;
                for (int unsigned i = 0; i < NUM_IN; i++) begin
                    sum[i] = {{(OW-WIDTH){bus.in_signed & bus.in_data[i*WIDTH + WIDTH - 1]}},
                              bus.in_data[i*WIDTH +: WIDTH]};
                end
            end
        end else begin : g_reg
            localparam int PCNT = lvl_cnt(k - 1);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld <= 1'b0;
                    sgn <= 1'b0;
                    for (int unsigned j = 0; j < CNT; j++) begin
                        sum[j] <= '0;
                    end
                end else if (!stall) begin
                    vld <= g_lvl[k-1].vld;
                    sgn <= g_lvl[k-1].sgn;
                    for (int unsigned j = 0; j < PCNT / 2; j++) begin
                        sum[j] <= g_lvl[k-1].sum[2*j] + g_lvl[k-1].sum[2*j + 1];
                    end
                    // Odd leftover operand rides through this level unchanged.
                    if (PCNT % 2 == 1) begin
                        sum[CNT-1] <= g_lvl[k-1].sum[PCNT-1];
                    end
                end
            end
        end
    end

    always_comb begin
        bus.out_valid  = g_lvl[LVL].vld;
        bus.out_signed = g_lvl[LVL].sgn;
        bus.out_data   = g_lvl[LVL].sum[0];
    end
endmodule

// File: tb/tb_pipelined_adder_tree.sv
module tb_pipelined_adder_tree;
    localparam int NUM_IN = 10;
    localparam int WIDTH  = 21;
    localparam int LVL    = 4;
    localparam int OW     = 25;
    localparam int DW     = NUM_IN * WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pipelined_adder_tree_if #(.NUM_IN(NUM_IN), .WIDTH(WIDTH)) bus ();

    pipelined_adder_tree #(.NUM_IN(NUM_IN), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          sgn;
        logic [OW-1:0] exp;
    } vec_t;

    typedef struct {
        logic [OW-1:0] d;
        logic          s;
    } res_t;

    int   checks   = 0;
    int   errors   = 0;
    int   accepted = 0;
    res_t exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] all_lanes(input logic [WIDTH-1:0] v);
        logic [DW-1:0] d;
        for (int i = 0; i < NUM_IN; i++) d[i*WIDTH +: WIDTH] = v;
        return d;
    endfunction

    function automatic logic [DW-1:0] one_lane(input int idx, input logic [WIDTH-1:0] v);
        logic [DW-1:0] d;
        d = '0;
        d[idx*WIDTH +: WIDTH] = v;
        return d;
    endfunction

    // Behavioural reference: exact integer sum, truncated to the result width.
    function automatic logic [OW-1:0] model(input logic [DW-1:0] d, input logic s);
        longint        acc;
        logic [WIDTH-1:0] l;
        logic [63:0]   r;
        acc = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            l = d[i*WIDTH +: WIDTH];
            if (s) acc += longint'($signed(l));
            else   acc += longint'({43'd0, l});
        end
        r = 64'(acc);
        return r[OW-1:0];
    endfunction

    // Called at a negedge with inputs already driven; scores the coming edge.
    task automatic step();
        res_t e;
        res_t n;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream extra: got %0h expected no result", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                chk("stream data", 64'(bus.out_data), 64'(e.d));
                chk("stream signed", 64'(bus.out_signed), 64'(e.s));
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            n.d = model(bus.in_data, bus.in_signed);
            n.s = bus.in_signed;
            exp_q.push_back(n);
            accepted++;
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t          tv [8];
        logic [DW-1:0] d;
        int            lat;
        bit            got;

        d = '0;
        for (int i = 0; i < NUM_IN; i++) d[i*WIDTH +: WIDTH] = WIDTH'(i + 1);

        tv[0] = '{all_lanes(21'h1FFFFF),      1'b0, 25'h13FFFF6};
        tv[1] = '{all_lanes(21'h1FFFFF),      1'b1, 25'h1FFFFF6};
        tv[2] = '{one_lane(9, 21'h100000),    1'b1, 25'h1F00000};
        tv[3] = '{one_lane(9, 21'h100000),    1'b0, 25'h0100000};
        tv[4] = '{d,                          1'b0, 25'd55};
        tv[5] = '{one_lane(0, 21'h1FFFFF) | one_lane(1, 21'h000001), 1'b1, 25'd0};
        tv[6] = '{all_lanes(21'h0FFFFF),      1'b1, 25'd10485750};
        tv[7] = '{all_lanes(21'h100000),      1'b1, 25'd23068672};

        bus.in_valid  = 1'b0;
        bus.in_signed = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset out_data", 64'(bus.out_data), 64'd0);
        chk("reset out_signed", 64'(bus.out_signed), 64'd0);
        chk("reset in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", 64'(bus.in_ready), 64'd1);
        chk("post-reset out_data", 64'(bus.out_data), 64'd0);

        // Single sets: value, mode and latency
        for (int v = 0; v < 8; v++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = tv[v].data;
            bus.in_signed = tv[v].sgn;
            bus.out_ready = 1'b1;
            lat = 0;
            got = 1'b0;
            for (int c = 1; c <= 12 && !got; c++) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                if (bus.out_valid) begin
                    got = 1'b1;
                    lat = c;
                end
            end
            chk($sformatf("vec%0d latency", v), 64'(lat), 64'(LVL));
            chk($sformatf("vec%0d data", v), 64'(bus.out_data), 64'(tv[v].exp));
            chk($sformatf("vec%0d signed", v), 64'(bus.out_signed), 64'(tv[v].sgn));
            @(negedge clk);
            chk($sformatf("vec%0d valid drop", v), 64'(bus.out_valid), 64'd0);
        end

        // Back-to-back: 8 sets, one result per cycle
        bus.out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            chk($sformatf("b2b valid c%0d", c), 64'(bus.out_valid), 64'((c >= 4 && c < 12) ? 1 : 0));
            if (bus.out_valid)
                chk($sformatf("b2b data c%0d", c), 64'(bus.out_data), 64'(c - 3));
            if (c < 8) begin
                bus.in_valid  = 1'b1;
                bus.in_signed = 1'b0;
                bus.in_data   = one_lane(0, WIDTH'(c + 1));
                #1;
                chk($sformatf("b2b in_ready c%0d", c), 64'(bus.in_ready), 64'd1);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Stall with a full pipe
        bus.out_ready = 1'b1;
        for (int v = 101; v <= 104; v++) begin
            bus.in_valid  = 1'b1;
            bus.in_signed = 1'b0;
            bus.in_data   = one_lane(0, WIDTH'(v));
            step();
        end
        bus.in_data   = one_lane(0, WIDTH'(105));
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk($sformatf("stall in_ready s%0d", s), 64'(bus.in_ready), 64'd0);
            chk($sformatf("stall out_valid s%0d", s), 64'(bus.out_valid), 64'd1);
            chk($sformatf("stall out_data s%0d", s), 64'(bus.out_data), 64'd101);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        chk("stall drain left", 64'(exp_q.size()), 64'd0);
        repeat (3) step();

        // Reset mid-stream with two sets in flight
        bus.out_ready = 1'b0;
        bus.in_signed = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = one_lane(3, WIDTH'(77));
        @(negedge clk);
        bus.in_data   = one_lane(4, WIDTH'(88));
        @(negedge clk);
        bus.in_valid  = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (bus.out_valid) got = 1'b1;
            else @(negedge clk);
        end
        chk("rst pre out_valid", 64'(bus.out_valid), 64'd1);
        chk("rst pre out_data", 64'(bus.out_data), 64'd77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst async out_data", 64'(bus.out_data), 64'd0);
        chk("rst async in_ready", 64'(bus.in_ready), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("rst after valid c%0d", c), 64'(bus.out_valid), 64'd0);
        end

        // Random traffic against the reference sum
        accepted = 0;
        for (int c = 0; c < 3000 && accepted < 200; c++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 8);
            bus.in_signed = 1'($urandom);
            for (int i = 0; i < NUM_IN; i++) begin
                case ($urandom_range(0, 3))
                    0:       bus.in_data[i*WIDTH +: WIDTH] = '1;
                    1:       bus.in_data[i*WIDTH +: WIDTH] = 21'h100000;
                    default: bus.in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                endcase
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        chk("random accepted", 64'(accepted), 64'd200);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
        chk("random drain left", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
